uartio_fifo: RTL

Buffered, parametrised successor to the CPU-facing UART port: same byte-wide register window and AD/DI/DO/rw/cs bus, but with RX and TX FIFOs of configurable depth, a programmable RX interrupt threshold, sticky error flags, FIFO flush, and internal loopback. It sits on the CPU peripheral bus and instantiates the existing uart_rx/uart_tx AXI-stream engines. Everything runs on a single clock; there is no separate clk_in domain.

---
 rtl/uartio_pkg.sv | 50 +++++
 rtl/uart_fifo.sv | 59 +++++
 rtl/uart_rx.sv | 81 ++++++++
 rtl/uart_tx.sv | 56 +++++
 rtl/uartio_fifo.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/uartio_pkg.sv
// Shared definitions for the buffered CPU-facing UART port: register map,
// STATUS/CONTROL bit positions and the RX threshold helper.
package uartio_pkg;

    // Byte-wide register window addressed by AD[2:0]
    typedef enum logic [2:0] {
        ADDR_DATA   = 3'd0,
        ADDR_STATUS = 3'd1,
        ADDR_PRE_HI = 3'd2,
        ADDR_PRE_LO = 3'd3,
        ADDR_RX_LVL = 3'd4,
        ADDR_TX_LVL = 3'd5,
        ADDR_RX_THR = 3'd6,
        ADDR_CTRL   = 3'd7
    } reg_addr_e;

    // STATUS bit positions
    localparam int ST_RRD = 0;
    localparam int ST_ROE = 1;
    localparam int ST_RFE = 2;
    localparam int ST_TNF = 3;
    localparam int ST_RIE = 4;
    localparam int ST_TIE = 5;
    localparam int ST_RIQ = 6;
    localparam int ST_TIQ = 7;

    // CONTROL write bit positions
    localparam int CT_FLUSH_RX = 0;
    localparam int CT_FLUSH_TX = 1;
    localparam int CT_CLR_ERR  = 2;
    localparam int CT_LBK      = 3;

    // STATUS byte layout, MSB first
    typedef struct packed {
        logic tiq;
        logic riq;
        logic tie;
        logic rie;
        logic tnf;
        logic rfe;
        logic roe;
        logic rrd;
    } status_t;

    // A programmed threshold of zero behaves like one
    function automatic logic [7:0] eff_threshold(input logic [7:0] thr);
        return (thr == 8'd0) ? 8'd1 : thr;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with push/pop/flush, full/empty flags and an occupancy
// counter one bit wider than the pointers so that full reads DEPTH.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == FULL_LVL);
    assign level   = level_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO only lands when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);

    // Storage write; no reset so the array maps onto RAM
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and level; flush overrides any same-cycle push or pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (do_push && !do_pop)      level_reg <= level_reg + LVL_ONE;
            else if (do_pop && !do_push) level_reg <= level_reg - LVL_ONE;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// AXI-stream UART receiver: 8N1, samples each bit mid-period, bit time =
// prescale*8 clocks. Overrun and frame errors are single-cycle pulses.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);
    localparam int BW = $clog2(DATA_WIDTH + 3);
    localparam logic [BW-1:0] START_BIT = BW'(DATA_WIDTH + 2);

    logic                  rxd_reg;
    logic [18:0]           cnt_reg;
    logic [BW-1:0]         bits_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [DATA_WIDTH-1:0] tdata_reg;
    logic                  tvalid_reg;
    logic                  ovr_reg;
    logic                  ferr_reg;
    logic [18:0]           period_m1;
    logic [18:0]           half_m1;

    assign period_m1     = (prescale == 16'd0) ? 19'd0 : ({prescale, 3'b000} - 19'd1);
    assign half_m1       = (prescale == 16'd0) ? 19'd0 : ({1'b0, prescale, 2'b00} - 19'd1);
    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign overrun_error = ovr_reg;
    assign frame_error   = ferr_reg;

    // Start detect, mid-bit sampling, stop check and output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_reg    <= 1'b1;
            cnt_reg    <= '0;
            bits_reg   <= '0;
            data_reg   <= '0;
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            ovr_reg    <= 1'b0;
            ferr_reg   <= 1'b0;
        end else begin
            rxd_reg  <= rxd;
            ovr_reg  <= 1'b0;
            ferr_reg <= 1'b0;
            if (tvalid_reg && m_axis_tready) tvalid_reg <= 1'b0;
            if (bits_reg == '0) begin
                if (!rxd_reg) begin
                    cnt_reg  <= half_m1;
                    bits_reg <= START_BIT;
                end
            end else if (cnt_reg != 19'd0) begin
                cnt_reg <= cnt_reg - 19'd1;
            end else begin
                cnt_reg  <= period_m1;
                bits_reg <= bits_reg - BW'(1);
                if (bits_reg == START_BIT) begin
                    // Line went back high mid start bit: treat as glitch
                    if (rxd_reg) bits_reg <= '0;
                end else if (bits_reg == BW'(1)) begin
                    if (rxd_reg) begin
                        tdata_reg  <= data_reg;
                        tvalid_reg <= 1'b1;
                        ovr_reg    <= tvalid_reg & ~m_axis_tready;
                    end else begin
                        ferr_reg <= 1'b1;
                    end
                end else begin
                    data_reg <= {rxd_reg, data_reg[DATA_WIDTH-1:1]};
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// AXI-stream UART transmitter: 8N1, bit time = prescale*8 clocks, idle high.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [15:0]           prescale
);
    localparam int BW = $clog2(DATA_WIDTH + 2);

    logic [DATA_WIDTH:0] shift_reg;
    logic [18:0]         cnt_reg;
    logic [BW-1:0]       bits_reg;
    logic                busy_reg;
    logic                txd_reg;
    logic [18:0]         period_m1;

    assign period_m1     = (prescale == 16'd0) ? 19'd0 : ({prescale, 3'b000} - 19'd1);
    assign s_axis_tready = ~busy_reg;
    assign busy          = busy_reg;
    assign txd           = txd_reg;

    // Load a byte when idle, then shift start, data LSB first and stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            bits_reg  <= '0;
            busy_reg  <= 1'b0;
            txd_reg   <= 1'b1;
        end else if (!busy_reg) begin
            if (s_axis_tvalid) begin
                shift_reg <= {1'b1, s_axis_tdata};
                txd_reg   <= 1'b0;
                cnt_reg   <= period_m1;
                bits_reg  <= BW'(DATA_WIDTH + 1);
                busy_reg  <= 1'b1;
            end
        end else if (cnt_reg != 19'd0) begin
            cnt_reg <= cnt_reg - 19'd1;
        end else if (bits_reg != '0) begin
            txd_reg   <= shift_reg[0];
            shift_reg <= {1'b1, shift_reg[DATA_WIDTH:1]};
            bits_reg  <= bits_reg - BW'(1);
            cnt_reg   <= period_m1;
        end else begin
            busy_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/uartio_fifo.sv
// Buffered CPU-facing UART port: byte register window over RX/TX FIFOs,
// programmable RX threshold interrupt, sticky errors, flush and loopback.
module uartio_fifo
    import uartio_pkg::*;
#(
    parameter int          RX_DEPTH       = 16,
    parameter int          TX_DEPTH       = 16,
    parameter logic [15:0] PRESCALE_RESET = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       rxd,
    output logic       txd
);
    localparam int RX_LW = $clog2(RX_DEPTH) + 1;
    localparam int TX_LW = $clog2(TX_DEPTH) + 1;

    logic [15:0]      prescale_reg;
    logic [7:0]       thr_reg;
    logic             tie_reg, rie_reg, lbk_reg;
    logic             rfe_reg, roe_reg, toe_reg;
    logic [7:0]       do_reg;
    logic [7:0]       rd_mux;

    logic             rd_en, wr_en, rd_data, wr_data, wr_ctrl;
    logic             flush_rx, flush_tx;

    logic [7:0]       rx_tdata, rx_head, tx_head;
    logic             rx_tvalid, rx_ovr, rx_ferr;
    logic             rx_full, rx_empty, rx_pop, rx_drop;
    logic [RX_LW-1:0] rx_level;
    logic             tx_full, tx_empty, tx_pop, tx_drop;
    logic             tx_tvalid, tx_tready, tx_busy, tx_line, rx_line;
    logic [TX_LW-1:0] tx_level;
    logic             riq, tiq;
    status_t          status;

    // Bus decode
    assign rd_en    = cs & rw;
    assign wr_en    = cs & ~rw;
    assign rd_data  = rd_en & (AD == ADDR_DATA);
    assign wr_data  = wr_en & (AD == ADDR_DATA);
    assign wr_ctrl  = wr_en & (AD == ADDR_CTRL);
    assign flush_rx = wr_ctrl & DI[CT_FLUSH_RX];
    assign flush_tx = wr_ctrl & DI[CT_FLUSH_TX];

    // RX side: reading an empty FIFO pops nothing; bytes that find no room are dropped
    assign rx_pop  = rd_data & ~rx_empty;
    assign rx_drop = rx_tvalid & rx_full & ~rx_pop;

    // TX side: the engine does not take a byte in a cycle that flushes the FIFO
    assign tx_tvalid = ~tx_empty & ~flush_tx;
    assign tx_pop    = tx_tvalid & tx_tready;
    assign tx_drop   = wr_data & tx_full & ~tx_pop;

    // Loopback feeds our own serial line to the receiver and parks txd high
    assign rx_line = lbk_reg ? tx_line : rxd;
    assign txd     = rst | lbk_reg | tx_line;

    // Interrupts are live conditions on registered state
    assign riq    = rie_reg & (8'(rx_level) >= eff_threshold(thr_reg));
    assign tiq    = tie_reg & tx_empty & ~tx_busy;
    assign irq    = riq | tiq;
    assign status = {tiq, riq, tie_reg, rie_reg, ~tx_full, rfe_reg, roe_reg, ~rx_empty};
    assign DO     = do_reg;

    uart_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_tvalid),
        .push_data (rx_tdata),
        .pop       (rx_pop),
        .flush     (flush_rx),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_data),
        .push_data (DI),
        .pop       (tx_pop),
        .flush     (flush_tx),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    uart_rx #(.DATA_WIDTH(8)) u_uart_rx (
        .clk           (clk),
        .rst           (rst),
        .m_axis_tdata  (rx_tdata),
        .m_axis_tvalid (rx_tvalid),
        .m_axis_tready (1'b1),
        .rxd           (rx_line),
        .overrun_error (rx_ovr),
        .frame_error   (rx_ferr),
        .prescale      (prescale_reg)
    );

    uart_tx #(.DATA_WIDTH(8)) u_uart_tx (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (tx_head),
        .s_axis_tvalid (tx_tvalid),
        .s_axis_tready (tx_tready),
        .txd           (tx_line),
        .busy          (tx_busy),
        .prescale      (prescale_reg)
    );

    // Configuration registers written from the bus
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_reg <= PRESCALE_RESET;
            thr_reg      <= 8'd1;
            tie_reg      <= 1'b0;
            rie_reg      <= 1'b0;
            lbk_reg      <= 1'b0;
        end else if (wr_en) begin
            case (AD)
                ADDR_STATUS: begin
                    tie_reg <= DI[ST_TIE];
                    rie_reg <= DI[ST_RIE];
                end
                ADDR_PRE_HI: prescale_reg[15:8] <= DI;
                ADDR_PRE_LO: prescale_reg[7:0]  <= DI;
                ADDR_RX_THR: thr_reg            <= DI;
                ADDR_CTRL:   lbk_reg            <= DI[CT_LBK];
                default:     ;
            endcase
        end
    end

    // Sticky error flags; a new event in the clearing cycle is kept
    always_ff @(posedge clk) begin
        if (rst) begin
            rfe_reg <= 1'b0;
            roe_reg <= 1'b0;
            toe_reg <= 1'b0;
        end else begin
            if (wr_ctrl && DI[CT_CLR_ERR]) begin
                rfe_reg <= 1'b0;
                roe_reg <= 1'b0;
                toe_reg <= 1'b0;
            end
            if (rx_drop || rx_ovr) roe_reg <= 1'b1;
            if (rx_ferr)           rfe_reg <= 1'b1;
            if (tx_drop)           toe_reg <= 1'b1;
        end
    end

    // Read data selection
    always_comb begin
        rd_mux = 8'h00;
        case (AD)
            ADDR_DATA:   rd_mux = rx_empty ? 8'h00 : rx_head;
            ADDR_STATUS: rd_mux = status;
            ADDR_PRE_HI: rd_mux = prescale_reg[15:8];
            ADDR_PRE_LO: rd_mux = prescale_reg[7:0];
            ADDR_RX_LVL: rd_mux = 8'(rx_level);
            ADDR_TX_LVL: rd_mux = 8'(tx_level);
            ADDR_RX_THR: rd_mux = thr_reg;
            ADDR_CTRL:   rd_mux = {4'b0000, lbk_reg, 2'b00, toe_reg};
            default:     rd_mux = 8'h00;
        endcase
    end

    // Registered read port; DO holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            do_reg <= 8'h00;
        end else if (rd_en) begin
            do_reg <= rd_mux;
        end
    end

endmodule
